// File: rtl/ex_divider_if.sv
// EX-stage divider bus: operation request from EX, stall request and results back.
// The master is the EX stage; the slave is the divider.
interface ex_divider_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             signed_div;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             annul;
    logic             stall_req;
    logic             done;
    logic [WIDTH-1:0] result_lo;
    logic [WIDTH-1:0] result_hi;

    modport master (
        output start, signed_div, dividend, divisor, annul,
        input  stall_req, done, result_lo, result_hi
    );

    modport slave (
        input  start, signed_div, dividend, divisor, annul,
        output stall_req, done, result_lo, result_hi
    );
endinterface

// File: rtl/ex_divider.sv
// Iterative restoring divider for MIPS DIV/DIVU.
// Produces one quotient bit per cycle and stalls the front of the pipeline while busy.
module ex_divider #(
    parameter int WIDTH = 32
) (
    input logic        clk,
    input logic        rst,
    ex_divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state, state_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic             neg_q, neg_r;
    logic [WIDTH-1:0] lo_q, hi_q;

    logic             dd_neg, dv_neg;
    logic [WIDTH-1:0] dd_abs, dv_abs;
    logic [WIDTH:0]   rem_shift, diff, rem_next;
    logic [WIDTH-1:0] quo_next;
    logic             last_iter;
    logic             div_zero;

    // quo starts as |dividend| and fills with quotient bits as dividend bits shift out.
    always_comb begin
        dd_neg    = bus.signed_div & bus.dividend[WIDTH-1];
        dv_neg    = bus.signed_div & bus.divisor[WIDTH-1];
        dd_abs    = dd_neg ? -bus.dividend : bus.dividend;
        dv_abs    = dv_neg ? -bus.divisor  : bus.divisor;
        div_zero  = (bus.divisor == '0);
        rem_shift = {rem[WIDTH-1:0], quo[WIDTH-1]};
        diff      = rem_shift - {1'b0, dvs};
        if (!diff[WIDTH]) begin
            rem_next = diff;
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = rem_shift;
            quo_next = {quo[WIDTH-2:0], 1'b0};
        end
        last_iter = (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (bus.annul) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (bus.start) state_next = div_zero ? DONE : BUSY;
                BUSY:    if (last_iter) state_next = DONE;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            rem   <= '0;
            quo   <= '0;
            dvs   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            lo_q  <= '0;
            hi_q  <= '0;
        end else if (!bus.annul) begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        rem   <= '0;
                        quo   <= dd_abs;
                        dvs   <= dv_abs;
                        neg_q <= dd_neg ^ dv_neg;
                        neg_r <= dd_neg;
                        cnt   <= '0;
                        if (div_zero) begin
                            lo_q <= '1;
                            hi_q <= bus.dividend;
                        end
                    end
                end
                BUSY: begin
                    rem <= rem_next;
                    quo <= quo_next;
                    cnt <= cnt + 1'b1;
                    if (last_iter) begin
                        lo_q <= neg_q ? -quo_next : quo_next;
                        hi_q <= neg_r ? -rem_next[WIDTH-1:0] : rem_next[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    // Reset also masks the stall so a held start cannot freeze the pipeline during reset.
    always_comb begin
        bus.stall_req = !rst && !bus.annul &&
                        (((state == IDLE) && bus.start) || (state == BUSY));
        bus.done      = (state == DONE);
        bus.result_lo = lo_q;
        bus.result_hi = hi_q;
    end
endmodule
